// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch stage. Owns the fetch PC, reads the
// combinational instruction ROM and buffers {pc, word} pairs in a small
// show-ahead queue drained by a valid/ready consumer. A redirect flushes
// the queue and restarts fetch at the new (word-aligned) address.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   word_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          push;
  logic          pop;
  logic          unused_bits;

  // Redirect target low bits are dropped to keep the fetch PC word-aligned.
  assign unused_bits = ^redirect_pc[1:0];

  assign imem_a      = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? word_mem[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : '0;

  // Handshake decode; a full queue never pushes, even alongside a pop.
  always_comb begin
    push      = !redirect && (count < FULL);
    pop       = instr_valid && instr_ready && !redirect;
    count_nxt = count + (AW + 1)'(push) - (AW + 1)'(pop);
  end

  // Fetch PC, queue pointers, occupancy and storage; redirect overrides all.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        word_mem[i] <= '0;
      end
    end else if (redirect) begin
      // A head handshaken in this cycle is consumed implicitly by the flush.
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]   <= fetch_pc;
        word_mem[wr_ptr] <= imem_rd;
        wr_ptr           <= wr_ptr + 1'b1;
        fetch_pc         <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
    end
  end

endmodule
